// File: rtl/pd_pluse_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : pd_pluse_timer_if
// Brief    : Control/flag bundle between a sequencer and pd_pluse_timer.
// Revision : 1.0 - initial release
// ============================================================================
interface pd_pluse_timer_if #(
    parameter int CW = 16
);
    logic          start;
    logic          abort;
    logic [1:0]    path_sel;
    logic [CW-1:0] dead_len;
    logic [CW-1:0] pw_len;
    logic          stateover;
    logic [5:0]    i;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, abort, path_sel, dead_len, pw_len, stateover,
        input  i, busy, done, err
    );

    modport slave (
        input  start, abort, path_sel, dead_len, pw_len, stateover,
        output i, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/pd_pluse_timer.sv
`default_nettype none
// ============================================================================
// Module   : pd_pluse_timer
// Brief    : Phase timer driving the 6-bit phase-flag bus of the pulse FSM.
// Revision : 1.0 - initial release
// ============================================================================
module pd_pluse_timer #(
    parameter int CW = 16
) (
    input  wire logic       dds,
    input  wire logic       rst_n,
    pd_pluse_timer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_DEAD     = 3'd2,
        S_PULSE    = 3'd3,
        S_WAITOVER = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    localparam logic [CW-1:0] c_one       = CW'(1);
    localparam logic [CW-1:0] c_wdog_last = CW'(14);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [CW-1:0] r_dead, w_dead_nxt;
    logic [CW-1:0] r_pw, w_pw_nxt;
    logic [5:0]    r_i, w_i_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;
    logic [CW-1:0] w_dead_last;
    logic [CW-1:0] w_pw_last;

    // A zero duration behaves as one cycle; the maximum duration cannot wrap
    // because only the terminal count is compared.
    assign w_dead_last = (r_dead == '0) ? '0 : r_dead - c_one;
    assign w_pw_last   = (r_pw   == '0) ? '0 : r_pw   - c_one;

    always_ff @(posedge dds or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_dead  <= '0;
            r_pw    <= '0;
            r_i     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_dead  <= w_dead_nxt;
            r_pw    <= w_pw_nxt;
            r_i     <= w_i_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_dead_nxt  = r_dead;
        w_pw_nxt    = r_pw;
        w_i_nxt     = r_i;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        if (r_state != S_IDLE && bus.abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_i_nxt     = '0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        w_sel_nxt   = bus.path_sel;
                        w_dead_nxt  = bus.dead_len;
                        w_pw_nxt    = bus.pw_len;
                        w_err_nxt   = 1'b0;
                        w_i_nxt     = {bus.path_sel[1], 3'b000, bus.path_sel[0], 1'b0};
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_i_nxt[0]  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DEAD;
                end
                S_DEAD: begin
                    if (r_cnt == w_dead_last) begin
                        w_i_nxt[2]  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_PULSE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == w_pw_last) begin
                        if (r_sel[0]) begin
                            w_i_nxt[4] = 1'b1;
                        end else begin
                            w_i_nxt[3] = 1'b1;
                        end
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAITOVER;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                S_WAITOVER: begin
                    // Completion wins over the watchdog on the final cycle.
                    if (!bus.stateover) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_FINISH;
                    end else if (r_cnt == c_wdog_last) begin
                        w_err_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                S_FINISH: begin
                    w_i_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = !r_err;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_i_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.i    = r_i;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pd_pluse_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pd_pluse_timer
// Brief    : Self-checking bench for pd_pluse_timer (event scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pd_pluse_timer;

    localparam int CW = 8;

    typedef struct {
        logic [1:0]    sel;
        logic [CW-1:0] dead;
        logic [CW-1:0] pw;
        int            so_k;
        int            exp_d;
        int            exp_p;
        logic          exp_bit4;
        logic          exp_done;
        logic          exp_err;
    } vec_t;

    typedef struct {
        string      name;
        int         cyc;
        logic [8:0] val;
    } ev_t;

    logic dds;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;
    logic [8:0] prev;
    ev_t  sb_q[$];
    vec_t vecs[7];
    vec_t hv;

    pd_pluse_timer_if #(.CW(CW)) bus ();

    pd_pluse_timer #(.CW(CW)) dut (
        .dds   (dds),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial dds = 1'b0;
    always #5 dds = ~dds;

    function automatic logic [8:0] snap();
        return {bus.i, bus.busy, bus.done, bus.err};
    endfunction

    task automatic push_ev(input string n, input int c, input logic [5:0] iv,
                           input logic b, input logic d, input logic e, input int cut);
        ev_t ev;
        if (c <= cut) begin
            ev.name = n;
            ev.cyc  = c;
            ev.val  = {iv, b, d, e};
            sb_q.push_back(ev);
        end
    endtask

    task automatic sample_check();
        logic [8:0] s;
        ev_t e;
        s = snap();
        if (s !== prev) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event cyc=%0d got=%b want=no change", cyc, s);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || s !== e.val) begin
                    fails++;
                    $display("FAIL event_%s got cyc=%0d {i,busy,done,err}=%b want cyc=%0d %b",
                             e.name, cyc, s, e.cyc, e.val);
                end
            end
            prev = s;
        end
    endtask

    task automatic step();
        @(negedge dds);
        sample_check();
        @(posedge dds);
        cyc++;
        #1;
    endtask

    task automatic check_drained(input string n);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain_%s got %0d pending events want 0 (next %s at cyc %0d)",
                     n, sb_q.size(), sb_q[0].name, sb_q[0].cyc);
            sb_q.delete();
        end
    endtask

    task automatic run_seq(input vec_t v, input int restart_off, input int abort_off);
        int s0, t2, tw, fin, end_c, cut;
        logic [5:0] base, pf;
        s0   = cyc;
        cut  = (abort_off >= 0) ? s0 + abort_off : s0 + 1000000;
        base = {v.sel[1], 3'b000, v.sel[0], 1'b0};
        t2   = s0 + 2 + v.exp_d;
        tw   = t2 + v.exp_p;
        pf   = base | 6'b000101 | (v.exp_bit4 ? 6'b010000 : 6'b001000);
        fin  = (v.so_k >= 0) ? tw + v.so_k + 2 : tw + 16;
        push_ev("load",  s0 + 1, base,              1'b1, 1'b0, 1'b0, cut);
        push_ev("arm",   s0 + 2, base | 6'b000001,  1'b1, 1'b0, 1'b0, cut);
        push_ev("dead",  t2,     base | 6'b000101,  1'b1, 1'b0, 1'b0, cut);
        push_ev("pulse", tw,     pf,                1'b1, 1'b0, 1'b0, cut);
        if (v.exp_err)
            push_ev("wdog", tw + 15, pf, 1'b1, 1'b0, 1'b1, cut);
        push_ev("finish", fin, 6'b0, 1'b0, v.exp_done, v.exp_err, cut);
        if (v.exp_done)
            push_ev("done_end", fin + 1, 6'b0, 1'b0, 1'b0, v.exp_err, cut);
        if (abort_off >= 0) begin
            push_ev("abort", s0 + abort_off + 1, 6'b0, 1'b0, 1'b0, 1'b0, 1000000);
            end_c = s0 + abort_off + 1;
        end else begin
            end_c = fin + 1;
        end

        bus.path_sel = v.sel;
        bus.dead_len = v.dead;
        bus.pw_len   = v.pw;
        while (cyc <= end_c + 8) begin
            bus.start     = (cyc == s0) || (restart_off > 0 && cyc == s0 + restart_off);
            bus.abort     = (abort_off >= 0 && cyc == s0 + abort_off);
            bus.stateover = !(v.so_k >= 0 && cyc >= tw + v.so_k && cyc < tw + v.so_k + 2);
            if (cyc > s0) begin
                bus.path_sel = 2'($urandom);
                bus.dead_len = CW'($urandom);
                bus.pw_len   = CW'($urandom);
            end
            step();
        end
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.stateover = 1'b1;
    endtask

    initial begin
        int s0;
        tests = 0;
        fails = 0;
        cyc   = 0;
        prev  = '0;

        //         sel    dead   pw    so_k  D    P    bit4  done  err
        vecs[0] = '{2'b10, 8'd5,   8'd8,   2,  5,   8,   1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'b01, 8'd3,   8'd4,   1,  3,   4,   1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 8'd0,   8'd0,   0,  1,   1,   1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 8'd2,   8'd3,  -1,  2,   3,   1'b0, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 8'd1,   8'd1,  14,  1,   1,   1'b0, 1'b1, 1'b0};
        vecs[5] = '{2'b01, 8'd255, 8'd255, 0,  255, 255, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{2'b00, 8'd7,   8'd2,   3,  7,   2,   1'b0, 1'b1, 1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.path_sel  = '0;
        bus.dead_len  = '0;
        bus.pw_len    = '0;
        bus.stateover = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();
        tests++;
        if (snap() !== 9'b0) begin
            fails++;
            $display("FAIL reset_state got %b want %b", snap(), 9'b0);
        end

        for (int k = 0; k < 7; k++) begin
            run_seq(vecs[k], 0, -1);
            check_drained($sformatf("vec%0d", k));
        end

        // start pulsed again while counting dead time must not disturb timing
        hv = '{2'b01, 8'd6, 8'd3, 1, 6, 3, 1'b1, 1'b1, 1'b0};
        run_seq(hv, 4, -1);
        check_drained("restart_in_dead");

        // abort while in PULSE
        hv = '{2'b10, 8'd2, 8'd6, -1, 2, 6, 1'b0, 1'b0, 1'b0};
        run_seq(hv, 0, 6);
        check_drained("abort_pulse");

        // abort together with start in IDLE: nothing may happen
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (6) step();
        tests++;
        if (bus.busy !== 1'b0 || bus.i !== 6'b0) begin
            fails++;
            $display("FAIL abort_start_idle got busy=%b i=%b want busy=0 i=000000", bus.busy, bus.i);
        end

        // asynchronous reset in the middle of DEAD
        s0 = cyc;
        push_ev("rst_load", s0 + 1, 6'b100010, 1'b1, 1'b0, 1'b0, 1000000);
        push_ev("rst_arm",  s0 + 2, 6'b100011, 1'b1, 1'b0, 1'b0, 1000000);
        bus.path_sel = 2'b11;
        bus.dead_len = 8'd10;
        bus.pw_len   = 8'd3;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        while (cyc < s0 + 5) step();
        check_drained("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.i !== 6'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got i=%b busy=%b done=%b err=%b want all 0",
                     bus.i, bus.busy, bus.done, bus.err);
        end
        prev = snap();
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check_drained("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
